// File: rtl/dht_sensor_controller.sv
// -----------------------------------------------------------------------------
// dht_sensor_controller
//
// Drives a DHT-family single-wire temperature/humidity sensor and presents the
// last good 32-bit sample to the Avalon PIO input port.
//
// The controller issues the host start pulse and times the sensor response and
// the 40 data bits. It verifies the checksum and keeps the last good sample on
// data_out. A transaction starts either from a periodic trigger or from an
// explicit start request.
//
// Request handshake: start is a single-cycle request. It is accepted only when
// busy is 0, and it is ignored while busy is 1. There is no back-pressure. Each
// accepted request ends in exactly one of these one-cycle pulses:
//   - data_valid   : data_out holds a new sample
//   - checksum_err : frame rejected, data_out unchanged
//   - timeout_err  : sensor phase expired, data_out unchanged
// The pulse appears on the first cycle in which busy is 0 again.
//
// Ports:
//   clk          in   system clock, single domain
//   reset_n      in   synchronous active-low reset
//   start        in   one-cycle request for an immediate sample
//   dht_in       in   sensed pin level, asynchronous to clk
//   dht_oe       out  1 drives the pin low, 0 releases it to the pull-up
//   data_out     out  {hum_int, hum_dec, temp_int, temp_dec}
//   data_valid   out  one-cycle pulse when data_out updates
//   checksum_err out  one-cycle pulse when a frame fails its checksum
//   timeout_err  out  one-cycle pulse when a sensor phase times out
//   busy         out  high in every state except IDLE
// -----------------------------------------------------------------------------
module dht_sensor_controller #(
  parameter int CLKS_PER_US   = 50,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter int PERIOD_US     = 2000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        checksum_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int PRE_W = $clog2(CLKS_PER_US + 1);
  localparam int PER_W = $clog2(PERIOD_US + 1);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLKS_PER_US - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD_US - 1);
  localparam logic [15:0]      START_LAST = 16'(START_LOW_US - 1);
  localparam logic [15:0]      TO_LAST    = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]      THRESH     = 16'(BIT_THRESH_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  // The current state is visible to checkers through this signal.
  state_t state;
  state_t state_nx;

  // ---------------------------------------------------------------------------
  // Pin synchronizer and edge register.
  // All three flops reset to 1 because the idle line is high.
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic line_q;
  logic rise;
  logic fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= dht_in;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign rise = sync2 & ~line_q;
  assign fall = ~sync2 & line_q;

  // ---------------------------------------------------------------------------
  // Phase timing.
  // The prescaler and the phase counter both restart on every state change.
  // Each phase is therefore measured in whole microseconds from its entry.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      phase_cnt;
  logic             tick;
  logic             state_change;

  assign tick         = (pre_cnt == PRE_LAST);
  assign state_change = (state_nx != state);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt   <= '0;
      phase_cnt <= '0;
    end else if (state_change) begin
      pre_cnt   <= '0;
      phase_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) phase_cnt <= phase_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Periodic trigger.
  // This path has its own prescaler, so the sampling period does not drift
  // with transaction activity. A trigger that arrives outside IDLE is lost.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] per_pre;
  logic [PER_W-1:0] per_cnt;
  logic             per_tick;
  logic             trigger;

  assign per_tick = (per_pre == PRE_LAST);
  assign trigger  = per_tick && (per_cnt == PER_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      per_pre <= '0;
      per_cnt <= '0;
    end else begin
      per_pre <= per_tick ? '0 : per_pre + PRE_W'(1);
      if (per_tick) per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath signals
  // ---------------------------------------------------------------------------
  logic [39:0] frame_q;
  logic [5:0]  bit_cnt;
  logic [7:0]  sum;
  logic        sum_ok;
  logic        bit_val;

  // The sum wraps to 8 bits, which gives the modulo-256 checksum directly.
  assign sum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign sum_ok  = (sum == frame_q[7:0]);
  assign bit_val = (phase_cnt > THRESH);

  // ---------------------------------------------------------------------------
  // Next-state logic and per-cycle actions
  // ---------------------------------------------------------------------------
  logic timed_out;
  logic shift_en;
  logic clr_frame;
  logic do_pass;
  logic do_fail;
  logic do_timeout;

  // A phase expires on the tick that completes its TIMEOUT_US-th microsecond.
  assign timed_out = tick && (phase_cnt == TO_LAST);

  always_comb begin
    state_nx   = state;
    shift_en   = 1'b0;
    clr_frame  = 1'b0;
    do_pass    = 1'b0;
    do_fail    = 1'b0;
    do_timeout = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start || trigger) state_nx = S_START_LOW;
      end

      S_START_LOW: begin
        if (tick && (phase_cnt == START_LAST)) state_nx = S_RELEASE;
      end

      S_RELEASE: begin
        if (fall) begin
          state_nx = S_RESP_LOW;
        end else if (timed_out) begin
          state_nx   = S_IDLE;
          do_timeout = 1'b1;
        end
      end

      S_RESP_LOW: begin
        if (rise) begin
          state_nx = S_RESP_HIGH;
        end else if (timed_out) begin
          state_nx   = S_IDLE;
          do_timeout = 1'b1;
        end
      end

      S_RESP_HIGH: begin
        if (fall) begin
          state_nx  = S_BIT_LOW;
          clr_frame = 1'b1;
        end else if (timed_out) begin
          state_nx   = S_IDLE;
          do_timeout = 1'b1;
        end
      end

      S_BIT_LOW: begin
        if (rise) begin
          state_nx = S_BIT_HIGH;
        end else if (timed_out) begin
          state_nx   = S_IDLE;
          do_timeout = 1'b1;
        end
      end

      S_BIT_HIGH: begin
        // An edge that arrives on the expiry cycle still counts as a data bit.
        if (fall) begin
          shift_en = 1'b1;
          state_nx = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
        end else if (timed_out) begin
          state_nx   = S_IDLE;
          do_timeout = 1'b1;
        end
      end

      S_CHECK: begin
        state_nx = S_IDLE;
        if (sum_ok) do_pass = 1'b1;
        else        do_fail = 1'b1;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, frame shift register, and registered result pulses.
  // The result pulses line up with the first IDLE cycle after the transaction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      frame_q      <= '0;
      bit_cnt      <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nx;
      data_valid   <= do_pass;
      checksum_err <= do_fail;
      timeout_err  <= do_timeout;

      if (clr_frame) begin
        frame_q <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        frame_q <= {frame_q[38:0], bit_val};
        bit_cnt <= bit_cnt + 6'd1;
      end

      if (do_pass) data_out <= frame_q[39:8];
    end
  end

  assign busy   = (state != S_IDLE);
  assign dht_oe = (state == S_START_LOW);

endmodule

// File: doc/dht_sensor_controller.md
# dht_sensor_controller

Sequences the single-wire DHT-family temperature/humidity sensor and produces the 32-bit sample word that the Avalon PIO input port presents to the Nios II software. The block issues the host start pulse, times the sensor response and 40 data bits, verifies the checksum, and holds the last good sample on `data_out`. Sampling is triggered periodically or on request. The block sits between the greenhouse sensor pin (bidirectional buffer at top level) and the PIO `in_port`.

## Interface
Parameters:
- `CLKS_PER_US`, 50: clock cycles per microsecond tick. 50 MHz system clock.
- `START_LOW_US`, 18000: host start pulse length.
- `BIT_THRESH_US`, 50: a high time greater than this decodes as `1`.
- `TIMEOUT_US`, 200: maximum wait in any sensor-driven phase.
- `PERIOD_US`, 2000000: auto-trigger period.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request for an immediate sample. Ignored while `busy`.
- `dht_in`  in  1  sensed pin level. Asynchronous to `clk`.
- `dht_oe`  out  1  1 drives the pin low; 0 releases it to the pull-up.
- `data_out`  out  32  `{hum_int, hum_dec, temp_int, temp_dec}`, one byte each. Feeds the PIO `in_port`.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `checksum_err`  out  1  one-cycle pulse when a frame is rejected on checksum.
- `timeout_err`  out  1  one-cycle pulse when a phase times out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `dht_in` passes through a 2-flop synchronizer. All edge detection uses the synchronized value and its one-cycle-delayed copy.
- Microsecond prescaler:
  - counts 0..`CLKS_PER_US`-1 and emits a tick at the terminal count;
  - clears on every state transition, so each phase counter starts aligned.
- Phase counter (16 bits) increments per tick and clears on every state transition.
- Period counter is free-running in ticks. It raises a trigger at `PERIOD_US`-1 and wraps to 0. If the trigger fires while `busy`, it is dropped.
- States:
  - IDLE: on `start` or trigger, go to START_LOW.
  - START_LOW: `dht_oe`=1. When phase count reaches `START_LOW_US`, go to RELEASE.
  - RELEASE: `dht_oe`=0. On falling edge, go to RESP_LOW.
  - RESP_LOW: on rising edge, go to RESP_HIGH.
  - RESP_HIGH: on falling edge, clear the bit counter and go to BIT_LOW.
  - BIT_LOW: on rising edge, go to BIT_HIGH.
  - BIT_HIGH: on falling edge:
    - shift bit (phase count > `BIT_THRESH_US`) into the 40-bit register, MSB first, and increment the bit counter;
    - when the count reaches 40, go to CHECK; otherwise go to BIT_LOW.
  - CHECK: one cycle, then go to IDLE.
    - Pass when `(b4+b3+b2+b1) mod 256 == b0`, where b4 is the first byte received. On pass, load `data_out` with bits [39:8] and pulse `data_valid`.
    - On fail, hold `data_out` and pulse `checksum_err`.
- Timeout: in RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, if the phase count reaches `TIMEOUT_US` before the awaited edge:
  - pulse `timeout_err` and go to IDLE;
  - hold `data_out`, force `dht_oe`=0, and discard the partial frame.
- `data_out` changes only on a passing CHECK. Software always reads the last good sample.

## Timing
- Reset values: `dht_oe`=0, `data_out`=0, `data_valid`=0, `checksum_err`=0, `timeout_err`=0, `busy`=0, state IDLE. All counters are 0 and synchronizer flops are 1 (idle-high line).
- Reset asserted mid-transaction:
  - the line is released on the next edge of `clk`;
  - no pulses are emitted and the partial frame is lost.
- `start` sampled high in IDLE: `busy` and `dht_oe` rise on the next cycle.
- START_LOW lasts `START_LOW_US`×`CLKS_PER_US` cycles, ±1.
- Edge detection latency is 3 cycles from pin change to state change: 2 synchronizer stages plus 1 edge register.
- Bit decision uses tick count only. A high time of exactly `BIT_THRESH_US` ticks decodes as `0`.
- CHECK occupies exactly one cycle. `data_valid`/`checksum_err` and the `data_out` update are visible on the cycle after CHECK, with `busy`=0 on that same cycle.
- `start` and trigger coinciding in IDLE start exactly one transaction.
- `start` in the same cycle as a CHECK or timeout exit is ignored, because `busy` is still 1.
- At most one of `data_valid`, `checksum_err`, `timeout_err` pulses per transaction.

## Test plan
Bench parameters: `CLKS_PER_US`=2, `START_LOW_US`=10, `TIMEOUT_US`=20, `PERIOD_US`=5000.
- Reset and idle: release `reset_n` with `dht_in`=1 and no `start` for 100 cycles. All outputs stay at reset values.
- Good frame: pulse `start`; the sensor model answers after the release and sends bytes 0x37,0x00,0x19,0x05,0x55.
  - `dht_oe` is high for 20±1 cycles.
  - `data_out`=0x37001905 with a single `data_valid` pulse; `busy` falls on the same cycle.
- Bad checksum: same frame with last byte 0x54. Expect a `checksum_err` pulse, `data_out` held at 0x37001905, and no `data_valid`.
- Sensor absent: pulse `start` with `dht_in` stuck high. Expect `timeout_err` 40 cycles after the RELEASE entry, `dht_oe`=0, and the block back in IDLE.
- Mid-frame abort: stop the sensor model after 17 bits with the line left high. Expect `timeout_err`; the next good frame decodes correctly with no residue from the partial frame.
- Trigger while busy: periodic trigger lands mid-frame. Expect no second transaction and the next start at the following period wrap. Also assert `reset_n` low for 1 cycle in BIT_HIGH: `dht_oe`=0 and IDLE next cycle, with no pulses.
